cvxif_kernel_dispatch: RTL and testbench

- Parametrised successor of the CV-X-IF custom-vector kernel mux. Routes one shared ap_ctrl handshake and three shared FIFO channels (in1, in2, out) to one of NUM_KERNELS HLS kernels, selected by opcode.
- Adds over the previous generation: a fire/fire_ready issue handshake with the opcode locked for the whole operation, rejection and flagging of illegal or unimplemented opcodes, per-kernel second-input masking, a registered completion pulse, and per-operation beat counters.
- Sits between the CV-X-IF coprocessor issue/FIFO logic and the HLS kernel instances.

---
 rtl/cvxif_kernel_dispatch.sv | 175 +++++++++++++++++
 tb/tb_cvxif_kernel_dispatch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_kernel_dispatch.sv
// rtl/cvxif_kernel_dispatch.sv - opcode-selected router of ap_ctrl and FIFO channels to HLS kernels
//
// Ports:
//   ap_clk, ap_rst_n            clock, synchronous active-low reset
//   fire / fire_ready / opcode  issue handshake; opcode is locked on accept
//   op_err                      combinational pulse for an illegal opcode
//   op_done                     registered completion pulse
//   busy                        an operation is in flight
//   ap_start/done/idle/ready    upstream ap_ctrl, mirrored from the selected kernel
//   in1_*, in2_*, out_r_*       upstream FIFO channels
//   k_*                         per-kernel ap_ctrl and FIFO channels (slot i on bit i)
//   in1_cnt, in2_cnt, out_cnt   saturating beat counts of the current/last operation
module cvxif_kernel_dispatch #(
    parameter int                     NUM_KERNELS = 4,
    parameter int                     OP_W        = 3,
    parameter int                     DATA_W      = 64,
    parameter logic [NUM_KERNELS-1:0] KERNEL_EN   = {NUM_KERNELS{1'b1}},
    parameter logic [NUM_KERNELS-1:0] HAS_IN2     = {NUM_KERNELS{1'b1}},
    parameter int                     CNT_W       = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          fire,
    output logic                          fire_ready,
    input  logic [OP_W-1:0]               opcode,
    output logic                          op_err,
    output logic                          op_done,
    output logic                          busy,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    output logic                          ap_ready,
    input  logic [DATA_W-1:0]             in1_dout,
    input  logic                          in1_empty_n,
    output logic                          in1_read,
    input  logic [DATA_W-1:0]             in2_dout,
    input  logic                          in2_empty_n,
    output logic                          in2_read,
    output logic [DATA_W-1:0]             out_r_din,
    input  logic                          out_r_full_n,
    output logic                          out_r_write,
    output logic [NUM_KERNELS-1:0]        k_ap_start,
    input  logic [NUM_KERNELS-1:0]        k_ap_done,
    input  logic [NUM_KERNELS-1:0]        k_ap_idle,
    input  logic [NUM_KERNELS-1:0]        k_ap_ready,
    output logic [NUM_KERNELS-1:0]        k_in1_empty_n,
    output logic [NUM_KERNELS-1:0]        k_in2_empty_n,
    output logic [NUM_KERNELS-1:0]        k_out_full_n,
    input  logic [NUM_KERNELS-1:0]        k_in1_read,
    input  logic [NUM_KERNELS-1:0]        k_in2_read,
    input  logic [NUM_KERNELS-1:0]        k_out_write,
    input  logic [NUM_KERNELS*DATA_W-1:0] k_out_din,
    output logic [CNT_W-1:0]              in1_cnt,
    output logic [CNT_W-1:0]              in2_cnt,
    output logic [CNT_W-1:0]              out_cnt
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [OP_W-1:0]  sel_q, sel_d, sel;
    logic [CNT_W-1:0] in1_cnt_q, in1_cnt_d, in2_cnt_q, in2_cnt_d, out_cnt_q, out_cnt_d;
    logic             op_done_q, op_done_d;
    logic             legal, accept, route;

    // The kernel data inputs are wired straight through by the top level;
    // the kernels read in1/in2 data directly, so only handshakes pass here.
    logic unused_data;
    assign unused_data = ^{in1_dout, in2_dout};

    // Compare against each slot index rather than indexing KERNEL_EN with
    // the opcode, so opcodes beyond NUM_KERNELS are illegal by construction.
    always_comb begin
        legal = 1'b0;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (opcode == OP_W'(i)) legal = KERNEL_EN[i];
        end
    end

    assign fire_ready = (state_q == IDLE);
    assign busy       = (state_q == ACTIVE);
    assign accept     = fire && fire_ready && legal;
    assign op_err     = fire && fire_ready && !legal;
    assign route      = (state_q == ACTIVE) || accept;
    // Bypass the opcode in the accept cycle for zero-latency ap_start.
    assign sel        = accept ? opcode : sel_q;

    always_comb begin
        k_ap_start    = '0;
        k_in1_empty_n = '0;
        k_in2_empty_n = '0;
        k_out_full_n  = '0;
        ap_done       = 1'b0;
        ap_idle       = 1'b1;
        ap_ready      = 1'b0;
        in1_read      = 1'b0;
        in2_read      = 1'b0;
        out_r_write   = 1'b0;
        out_r_din     = '0;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (route && (sel == OP_W'(i))) begin
                k_ap_start[i]    = ap_start;
                k_in1_empty_n[i] = in1_empty_n;
                k_in2_empty_n[i] = in2_empty_n & HAS_IN2[i];
                k_out_full_n[i]  = out_r_full_n;
                ap_done          = k_ap_done[i];
                ap_idle          = k_ap_idle[i];
                ap_ready         = k_ap_ready[i];
                in1_read         = k_in1_read[i];
                in2_read         = k_in2_read[i] & HAS_IN2[i];
                out_r_write      = k_out_write[i];
                out_r_din        = k_out_din[i*DATA_W +: DATA_W];
            end
        end
    end

    // Clear-on-accept and increment resolve together: a beat in the accept
    // cycle leaves the counter at 1.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                  input logic clr, input logic beat);
        logic [CNT_W-1:0] base;
        base = clr ? '0 : cur;
        if (beat && (base != {CNT_W{1'b1}})) return base + 1'b1;
        return base;
    endfunction

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        op_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACTIVE;
                    sel_d   = opcode;
                end
            end
            ACTIVE: begin
                // In ACTIVE the mux selects sel_q, so ap_done is k_ap_done[sel_q].
                if (ap_done) begin
                    state_d   = IDLE;
                    op_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        in1_cnt_d = next_cnt(in1_cnt_q, accept, in1_read && in1_empty_n);
        in2_cnt_d = next_cnt(in2_cnt_q, accept, in2_read && in2_empty_n);
        out_cnt_d = next_cnt(out_cnt_q, accept, out_r_write && out_r_full_n);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            op_done_q <= 1'b0;
            in1_cnt_q <= '0;
            in2_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            op_done_q <= op_done_d;
            in1_cnt_q <= in1_cnt_d;
            in2_cnt_q <= in2_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign op_done = op_done_q;
    assign in1_cnt = in1_cnt_q;
    assign in2_cnt = in2_cnt_q;
    assign out_cnt = out_cnt_q;

endmodule

// File: tb/tb_cvxif_kernel_dispatch.sv
// tb/tb_cvxif_kernel_dispatch.sv - directed self-checking bench for cvxif_kernel_dispatch
module tb_cvxif_kernel_dispatch;

    localparam int NK = 4;
    localparam int OW = 3;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared stimulus
    logic           rst_n, fire, ap_start;
    logic [OW-1:0]  opcode;
    logic [DW-1:0]  in1_dout, in2_dout;
    logic           in1_empty_n, in2_empty_n, out_r_full_n;
    logic [NK-1:0]  k_ap_done, k_ap_idle, k_ap_ready, k_in1_read, k_in2_read, k_out_write;
    logic [NK*DW-1:0] k_out_din;

    // Main instance: all slots enabled, slot 3 without in2, 16-bit counters
    logic fire_ready, op_err, op_done, busy, ap_done, ap_idle, ap_ready;
    logic in1_read, in2_read, out_r_write;
    logic [DW-1:0] out_r_din;
    logic [NK-1:0] k_ap_start, k_in1_empty_n, k_in2_empty_n, k_out_full_n;
    logic [15:0]   in1_cnt, in2_cnt, out_cnt;

    // Second instance: slot 1 disabled, 3-bit counters
    logic fire_ready_s, op_err_s, op_done_s, busy_s, ap_done_s, ap_idle_s, ap_ready_s;
    logic in1_read_s, in2_read_s, out_r_write_s;
    logic [DW-1:0] out_r_din_s;
    logic [NK-1:0] k_ap_start_s, k_in1_empty_n_s, k_in2_empty_n_s, k_out_full_n_s;
    logic [2:0]    in1_cnt_s, in2_cnt_s, out_cnt_s;

    cvxif_kernel_dispatch #(.NUM_KERNELS(NK), .OP_W(OW), .DATA_W(DW),
        .KERNEL_EN(4'b1111), .HAS_IN2(4'b0111), .CNT_W(16)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .fire(fire), .fire_ready(fire_ready),
        .opcode(opcode), .op_err(op_err), .op_done(op_done), .busy(busy),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .in1_dout(in1_dout), .in1_empty_n(in1_empty_n), .in1_read(in1_read),
        .in2_dout(in2_dout), .in2_empty_n(in2_empty_n), .in2_read(in2_read),
        .out_r_din(out_r_din), .out_r_full_n(out_r_full_n), .out_r_write(out_r_write),
        .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
        .k_ap_ready(k_ap_ready), .k_in1_empty_n(k_in1_empty_n),
        .k_in2_empty_n(k_in2_empty_n), .k_out_full_n(k_out_full_n),
        .k_in1_read(k_in1_read), .k_in2_read(k_in2_read), .k_out_write(k_out_write),
        .k_out_din(k_out_din), .in1_cnt(in1_cnt), .in2_cnt(in2_cnt), .out_cnt(out_cnt));

    cvxif_kernel_dispatch #(.NUM_KERNELS(NK), .OP_W(OW), .DATA_W(DW),
        .KERNEL_EN(4'b1101), .HAS_IN2(4'b0111), .CNT_W(3)) dut_s (
        .ap_clk(clk), .ap_rst_n(rst_n), .fire(fire), .fire_ready(fire_ready_s),
        .opcode(opcode), .op_err(op_err_s), .op_done(op_done_s), .busy(busy_s),
        .ap_start(ap_start), .ap_done(ap_done_s), .ap_idle(ap_idle_s), .ap_ready(ap_ready_s),
        .in1_dout(in1_dout), .in1_empty_n(in1_empty_n), .in1_read(in1_read_s),
        .in2_dout(in2_dout), .in2_empty_n(in2_empty_n), .in2_read(in2_read_s),
        .out_r_din(out_r_din_s), .out_r_full_n(out_r_full_n), .out_r_write(out_r_write_s),
        .k_ap_start(k_ap_start_s), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
        .k_ap_ready(k_ap_ready), .k_in1_empty_n(k_in1_empty_n_s),
        .k_in2_empty_n(k_in2_empty_n_s), .k_out_full_n(k_out_full_n_s),
        .k_in1_read(k_in1_read), .k_in2_read(k_in2_read), .k_out_write(k_out_write),
        .k_out_din(k_out_din), .in1_cnt(in1_cnt_s), .in2_cnt(in2_cnt_s), .out_cnt(out_cnt_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fire = 1'b0; opcode = '0; ap_start = 1'b0;
        in1_dout = '0; in2_dout = '0; in1_empty_n = 1'b0; in2_empty_n = 1'b0;
        out_r_full_n = 1'b0; k_ap_done = '0; k_ap_idle = '1; k_ap_ready = '0;
        k_in1_read = '0; k_in2_read = '0; k_out_write = '0; k_out_din = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (fire_ready !== 1'b1) begin failures++; $display("FAIL reset_fire_ready got=%0b exp=1", fire_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL reset_ap_idle got=%0b exp=1", ap_idle); end
        checks++; if (k_ap_start !== 4'b0000) begin failures++; $display("FAIL reset_k_ap_start got=%b exp=0000", k_ap_start); end
        checks++; if ({in1_cnt, in2_cnt, out_cnt} !== 48'h0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h/%0h exp=0", in1_cnt, in2_cnt, out_cnt); end
        checks++; if (op_done !== 1'b0) begin failures++; $display("FAIL reset_op_done got=%0b exp=0", op_done); end
    endtask

    task automatic test_basic();
        opcode = 3'd2; fire = 1'b1; ap_start = 1'b1;
        in1_empty_n = 1'b1; in2_empty_n = 1'b1; out_r_full_n = 1'b1;
        #1;
        checks++; if (k_ap_start !== 4'b0100) begin failures++; $display("FAIL basic_start_bypass got=%b exp=0100", k_ap_start); end
        tick();
        fire = 1'b0; ap_start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        k_in1_read = 4'b0100; k_in2_read = 4'b0100; k_out_write = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            k_out_din = '0;
            k_out_din[2*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(i);
            #1;
            if (i == 3) begin
                checks++; if (out_r_din !== 64'hA5A5_0000_0000_0003) begin failures++; $display("FAIL basic_out_din got=%0h exp=a5a5000000000003", out_r_din); end
                checks++; if ({in1_read, in2_read, out_r_write} !== 3'b111) begin failures++; $display("FAIL basic_handshake got=%b exp=111", {in1_read, in2_read, out_r_write}); end
            end
            tick();
        end
        k_in1_read = '0; k_in2_read = '0; k_out_write = '0; k_out_din = '0;
        checks++; if ({in1_cnt, in2_cnt, out_cnt} !== {16'd8, 16'd8, 16'd8}) begin failures++; $display("FAIL basic_cnt got=%0d/%0d/%0d exp=8/8/8", in1_cnt, in2_cnt, out_cnt); end
        checks++; if (in1_cnt_s !== 3'd7) begin failures++; $display("FAIL basic_sat_cnt got=%0d exp=7", in1_cnt_s); end
        k_ap_done = 4'b0100;
        #1;
        checks++; if (ap_done !== 1'b1 || op_done !== 1'b0) begin failures++; $display("FAIL basic_done_comb got=%0b%0b exp=10", ap_done, op_done); end
        tick();
        k_ap_done = '0;
        checks++; if (op_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_op_done got=%0b busy=%0b exp=1/0", op_done, busy); end
        tick();
        checks++; if (op_done !== 1'b0) begin failures++; $display("FAIL basic_op_done_pulse got=%0b exp=0", op_done); end
        checks++; if (in1_cnt !== 16'd8) begin failures++; $display("FAIL basic_cnt_hold got=%0d exp=8", in1_cnt); end
    endtask

    task automatic test_lock();
        opcode = 3'd2; fire = 1'b1;
        tick();
        opcode = 3'd1; ap_start = 1'b1;
        #1;
        checks++; if (fire_ready !== 1'b0) begin failures++; $display("FAIL lock_fire_ready got=%0b exp=0", fire_ready); end
        checks++; if (k_ap_start !== 4'b0100) begin failures++; $display("FAIL lock_start got=%b exp=0100", k_ap_start); end
        checks++; if (k_in1_empty_n !== 4'b0100) begin failures++; $display("FAIL lock_route got=%b exp=0100", k_in1_empty_n); end
        k_ap_done = 4'b0100;
        tick();
        k_ap_done = '0;
        k_in1_read = 4'b0010;
        #1;
        checks++; if (fire_ready !== 1'b1 || k_ap_start !== 4'b0010) begin failures++; $display("FAIL lock_reaccept got=%0b/%b exp=1/0010", fire_ready, k_ap_start); end
        checks++; if (op_err_s !== 1'b1 || op_err !== 1'b0) begin failures++; $display("FAIL lock_op_err_s got=%0b/%0b exp=1/0", op_err_s, op_err); end
        tick();
        fire = 1'b0; ap_start = 1'b0; k_in1_read = '0;
        checks++; if (busy !== 1'b1 || busy_s !== 1'b0) begin failures++; $display("FAIL lock_busy got=%0b/%0b exp=1/0", busy, busy_s); end
        checks++; if (in1_cnt !== 16'd1) begin failures++; $display("FAIL accept_beat_cnt got=%0d exp=1", in1_cnt); end
        k_ap_done = 4'b0010;
        tick();
        k_ap_done = '0;
        tick();
    endtask

    task automatic test_illegal();
        opcode = 3'd5; fire = 1'b1;
        #1;
        checks++; if (op_err !== 1'b1 || op_err_s !== 1'b1) begin failures++; $display("FAIL illegal_op_err got=%0b/%0b exp=1/1", op_err, op_err_s); end
        checks++; if (fire_ready !== 1'b1) begin failures++; $display("FAIL illegal_fire_ready got=%0b exp=1", fire_ready); end
        tick();
        fire = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || busy_s !== 1'b0 || op_err !== 1'b0) begin failures++; $display("FAIL illegal_idle got=%0b%0b%0b exp=000", busy, busy_s, op_err); end
    endtask

    task automatic test_in2_mask();
        opcode = 3'd3; fire = 1'b1;
        tick();
        fire = 1'b0;
        in1_empty_n = 1'b1; in2_empty_n = 1'b1; k_in2_read = 4'b1000;
        #1;
        checks++; if (k_in2_empty_n !== 4'b0000 || in2_read !== 1'b0) begin failures++; $display("FAIL in2_mask got=%b/%0b exp=0000/0", k_in2_empty_n, in2_read); end
        checks++; if (k_in1_empty_n !== 4'b1000) begin failures++; $display("FAIL in2_mask_in1 got=%b exp=1000", k_in1_empty_n); end
        tick(); tick(); tick();
        checks++; if (in2_cnt !== 16'd0) begin failures++; $display("FAIL in2_mask_cnt got=%0d exp=0", in2_cnt); end
        k_in2_read = '0; k_ap_done = 4'b1000;
        tick();
        k_ap_done = '0;
        tick();
    endtask

    task automatic test_backpressure_reset();
        opcode = 3'd0; fire = 1'b1;
        tick();
        fire = 1'b0;
        in1_empty_n = 1'b1; k_in1_read = 4'b0001; k_out_write = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            out_r_full_n = (i % 2 == 0);
            #1;
            if (i == 1) begin
                checks++; if (k_out_full_n !== 4'b0000 || out_r_write !== 1'b1) begin failures++; $display("FAIL bp_full_n got=%b/%0b exp=0000/1", k_out_full_n, out_r_write); end
            end
            tick();
        end
        k_in1_read = '0; k_out_write = '0; out_r_full_n = 1'b1;
        checks++; if (in1_cnt !== 16'd10 || in1_cnt_s !== 3'd7) begin failures++; $display("FAIL sat_in1 got=%0d/%0d exp=10/7", in1_cnt, in1_cnt_s); end
        checks++; if (out_cnt !== 16'd5 || out_cnt_s !== 3'd5) begin failures++; $display("FAIL bp_out_cnt got=%0d/%0d exp=5/5", out_cnt, out_cnt_s); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || busy_s !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b/%0b exp=0/0", busy, busy_s); end
        checks++; if ({in1_cnt, out_cnt} !== 32'h0 || in1_cnt_s !== 3'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d/%0d/%0d exp=0", in1_cnt, out_cnt, in1_cnt_s); end
        checks++; if (k_in1_empty_n !== 4'b0000) begin failures++; $display("FAIL rst_mid_route got=%b exp=0000", k_in1_empty_n); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lock();
        test_illegal();
        test_in2_mask();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
